// File: rtl/lpm_divide_seq.sv
// Iterative restoring divider with start/busy/done handshake.
// One quotient bit per enabled clock; signed mode divides magnitudes and fixes signs at the end.
module lpm_divide_seq #(
    parameter int    lpm_widthn         = 8,
    parameter int    lpm_widthd         = 8,
    parameter string lpm_representation = "UNSIGNED"
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic                  clken,
    input  logic                  start,
    input  logic [lpm_widthn-1:0] numer,
    input  logic [lpm_widthd-1:0] denom,
    output logic                  busy,
    output logic                  done,
    output logic [lpm_widthn-1:0] quotient,
    output logic [lpm_widthd-1:0] remain,
    output logic                  div_zero
);
    localparam int WN = lpm_widthn;
    localparam int WD = lpm_widthd;
    localparam int CW = $clog2(WN + 1);
    localparam bit IS_SIGNED = (lpm_representation == "SIGNED");

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WD-1:0] rem_q, rem_d;
    logic [WN-1:0] qsh_q, qsh_d;
    logic [WD-1:0] dvs_q, dvs_d;
    logic [WD-1:0] nlo_q, nlo_d;
    logic          nneg_q, nneg_d;
    logic          dneg_q, dneg_d;
    logic [WN-1:0] quotient_q, quotient_d;
    logic [WD-1:0] remain_q, remain_d;
    logic          dz_q, dz_d;

    logic          n_neg, d_neg, ge;
    logic [WN-1:0] n_mag;
    logic [WD-1:0] d_mag;
    logic [WD:0]   trial, diff;

    always_comb begin
        n_neg = IS_SIGNED && numer[WN-1];
        d_neg = IS_SIGNED && denom[WD-1];
        // The most-negative numerator negates to itself, which is its exact unsigned magnitude.
        n_mag = n_neg ? (~numer + 1'b1) : numer;
        d_mag = d_neg ? (~denom + 1'b1) : denom;
        trial = {rem_q, qsh_q[WN-1]};
        diff  = trial - {1'b0, dvs_q};
        ge    = (trial >= {1'b0, dvs_q});
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        qsh_d      = qsh_q;
        dvs_d      = dvs_q;
        nlo_d      = nlo_q;
        nneg_d     = nneg_q;
        dneg_d     = dneg_q;
        quotient_d = quotient_q;
        remain_d   = remain_q;
        dz_d       = dz_q;
        case (state_q)
            S_CALC: begin
                if (cnt_q == CW'(WN)) begin
                    state_d = S_DONE;
                    if (dvs_q == '0) begin
                        quotient_d = '1;
                        remain_d   = nlo_q;
                        dz_d       = 1'b1;
                    end else begin
                        quotient_d = (nneg_q ^ dneg_q) ? (~qsh_q + 1'b1) : qsh_q;
                        remain_d   = nneg_q ? (~rem_q + 1'b1) : rem_q;
                        dz_d       = 1'b0;
                    end
                end else begin
                    // A failed trial is below the divisor, so its top bit is always zero.
                    rem_d = ge ? diff[WD-1:0] : trial[WD-1:0];
                    qsh_d = {qsh_q[WN-2:0], ge};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    rem_d   = '0;
                    qsh_d   = n_mag;
                    dvs_d   = d_mag;
                    nlo_d   = numer[WD-1:0];
                    nneg_d  = n_neg;
                    dneg_d  = d_neg;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            qsh_q      <= '0;
            dvs_q      <= '0;
            nlo_q      <= '0;
            nneg_q     <= 1'b0;
            dneg_q     <= 1'b0;
            quotient_q <= '0;
            remain_q   <= '0;
            dz_q       <= 1'b0;
        end else if (clken) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            qsh_q      <= qsh_d;
            dvs_q      <= dvs_d;
            nlo_q      <= nlo_d;
            nneg_q     <= nneg_d;
            dneg_q     <= dneg_d;
            quotient_q <= quotient_d;
            remain_q   <= remain_d;
            dz_q       <= dz_d;
        end
    end

    assign busy     = (state_q == S_CALC);
    assign done     = (state_q == S_DONE);
    assign quotient = quotient_q;
    assign remain   = remain_q;
    assign div_zero = dz_q;
endmodule

// File: tb/tb_lpm_divide_seq.sv
// Scoreboard bench for lpm_divide_seq: one unsigned and one signed 8/8 instance,
// directed vectors pushed at issue time, independent monitors pop on each done.
module tb_lpm_divide_seq;
    logic       clk = 1'b0;
    logic       aclr_n, clken;
    logic       start_u, start_s;
    logic [7:0] numer, denom;
    logic       busy_u, done_u, dz_u, busy_s, done_s, dz_s;
    logic [7:0] q_u, r_u, q_s, r_s;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         extra;
        int         due;
    } exp_t;

    exp_t qu[$];
    exp_t qs[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic en_at_edge = 1'b0;

    lpm_divide_seq #(.lpm_widthn(8), .lpm_widthd(8), .lpm_representation("UNSIGNED")) u_dut (
        .clock(clk), .aclr_n(aclr_n), .clken(clken), .start(start_u),
        .numer(numer), .denom(denom), .busy(busy_u), .done(done_u),
        .quotient(q_u), .remain(r_u), .div_zero(dz_u)
    );

    lpm_divide_seq #(.lpm_widthn(8), .lpm_widthd(8), .lpm_representation("SIGNED")) s_dut (
        .clock(clk), .aclr_n(aclr_n), .clken(clken), .start(start_s),
        .numer(numer), .denom(denom), .busy(busy_s), .done(done_s),
        .quotient(q_s), .remain(r_s), .div_zero(dz_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        en_at_edge <= clken;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Only the first negedge after the enabled edge that entered DONE counts as a new result.
    always @(negedge clk) begin
        if (aclr_n && en_at_edge && done_u) begin
            if (qu.size() == 0) chk("u_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = qu.pop_front();
                chk("u_quotient", q_u, e.q);
                chk("u_remain", r_u, e.r);
                chk("u_div_zero", dz_u, e.dz);
                chk("u_busy_at_done", busy_u, 0);
                chk("u_latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (aclr_n && en_at_edge && done_s) begin
            if (qs.size() == 0) chk("s_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = qs.pop_front();
                chk("s_quotient", q_s, e.q);
                chk("s_remain", r_s, e.r);
                chk("s_div_zero", dz_s, e.dz);
                chk("s_latency", cyc, e.due);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic go(input bit sgn, input logic [7:0] n, input logic [7:0] d,
                      input logic [7:0] eq, input logic [7:0] er, input logic edz,
                      input int extra, input bit push);
        exp_t e;
        numer = n;
        denom = d;
        if (sgn) start_s = 1'b1; else start_u = 1'b1;
        @(posedge clk);
        #1;
        e.q = eq; e.r = er; e.dz = edz; e.extra = extra;
        e.due = cyc + 9 + extra;
        if (push) begin
            if (sgn) qs.push_back(e); else qu.push_back(e);
        end
        @(negedge clk);
        start_s = 1'b0;
        start_u = 1'b0;
    endtask

    task automatic wait_done(input bit sgn);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = sgn ? done_s : done_u;
        end
        if (!seen) chk(sgn ? "s_done_timeout" : "u_done_timeout", 0, 1);
    endtask

    initial begin
        aclr_n = 1'b0; clken = 1'b1; start_u = 1'b0; start_s = 1'b0;
        numer = '0; denom = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_u, 0);
        chk("rst_done", done_u, 0);
        chk("rst_quotient", q_u, 0);
        chk("rst_remain", r_u, 0);
        chk("rst_div_zero", dz_u, 0);
        chk("rst_s_quotient", q_s, 0);
        aclr_n = 1'b1;
        @(negedge clk);

        go(0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0, 1); wait_done(0);

        @(negedge clk); go(1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 0, 1); wait_done(1);
        @(negedge clk); go(1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 0, 1); wait_done(1);
        @(negedge clk); go(1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 0, 1); wait_done(1);

        @(negedge clk); go(0, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1, 0, 1); wait_done(0);
        @(negedge clk); go(0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 0, 1); wait_done(0);

        // clock-enable stall of five edges mid-CALC
        @(negedge clk); go(0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 5, 1);
        repeat (3) @(negedge clk);
        clken = 1'b0;
        repeat (5) @(negedge clk);
        clken = 1'b1;
        wait_done(0);

        // start while busy is ignored; start in the DONE cycle chains back-to-back
        @(negedge clk); go(0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0, 1);
        repeat (2) @(negedge clk);
        numer = 8'd50; denom = 8'd5; start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        wait_done(0);
        go(0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 0, 1);
        wait_done(0);

        // asynchronous abort mid-CALC
        @(negedge clk); go(0, 8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        aclr_n = 1'b0;
        #1;
        chk("abort_busy", busy_u, 0);
        chk("abort_done", done_u, 0);
        chk("abort_quotient", q_u, 0);
        chk("abort_remain", r_u, 0);
        chk("abort_div_zero", dz_u, 0);
        repeat (3) @(negedge clk);
        aclr_n = 1'b1;
        repeat (15) @(negedge clk);
        go(0, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 0, 1);
        wait_done(0);

        repeat (2) @(negedge clk);
        chk("u_queue_drained", qu.size(), 0);
        chk("s_queue_drained", qs.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
